// File: rtl/typing_pkg.sv
// typing_pkg: shared state encoding, ASCII constants and default geometry for typing_tracker.
package typing_pkg;
    typedef enum logic [1:0] {IDLE, CHECK, PEEK, DONE} state_t;
    localparam logic [6:0] ASCII_NUL = 7'h00;
    localparam logic [6:0] ASCII_BS = 7'h08;
    localparam logic PROMPT_SEL = 1'b1;
    localparam int DEF_COLS = 64;
    localparam int DEF_ROWS = 5;
endpackage

// File: rtl/cursor_counter.sv
// cursor_counter: column/row cursor with row wrap in both directions and a linear index kept in step.
// Ports: clk, reset_n (sync, active-low); inc/dec/clr step, step back or zero the cursor;
//        x/y cursor position, idx = y*COLS + x (registered alongside x/y).
module cursor_counter #(
    parameter int COLS = 64,
    parameter int ROWS = 5,
    parameter int XW = $clog2(COLS),
    parameter int YW = $clog2(ROWS + 1),
    parameter int IW = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [IW-1:0] idx
);
    // idx is its own register so the prompt address is valid the same cycle x/y change,
    // and stays correct even when COLS is not a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            x <= '0;
            y <= '0;
            idx <= '0;
        end else if (inc) begin
            if (x == XW'(COLS - 1)) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
            idx <= idx + 1'b1;
        end else if (dec && idx != '0) begin
            if (x == '0) begin
                x <= XW'(COLS - 1);
                y <= y - 1'b1;
            end else begin
                x <= x - 1'b1;
            end
            idx <= idx - 1'b1;
        end
    end
endmodule

// File: rtl/typing_tracker.sv
// typing_tracker: compares keystrokes against prompt_rom and tracks the typing cursor for the renderer.
// Ports: clk, reset_n (sync, active-low); key_valid/key_ascii/key_ready keystroke handshake;
//        restart (leaves DONE); letter_index/selection/prompt_char prompt_rom access;
//        correct_index_x/y cursor; hit/miss one-cycle pulses; done level; keystroke_cnt/error_cnt.
// Build option: define TRACKER_BACKSPACE_EN to make 0x08 move the cursor back instead of comparing.
module typing_tracker
    import typing_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int PROMPT_LEN = 320,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             key_valid,
    input  logic [7:0]       key_ascii,
    output logic             key_ready,
    input  logic             restart,
    output logic [11:0]      letter_index,
    output logic             selection,
    input  logic [6:0]       prompt_char,
    output logic [31:0]      correct_index_x,
    output logic [31:0]      correct_index_y,
    output logic             hit,
    output logic             miss,
    output logic             done,
    output logic [CNT_W-1:0] keystroke_cnt,
    output logic [CNT_W-1:0] error_cnt
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS + 1);
    localparam logic [11:0] END_IDX = 12'(PROMPT_LEN);

    state_t state, next;
    logic [6:0] key_q;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic inc, dec, clr, accept, hit_d, miss_d;
    logic unused;

    // Bit 7 of the keystroke carries no prompt information.
    assign unused = key_ascii[7];
    assign selection = PROMPT_SEL;
    assign key_ready = state == IDLE;
    assign done = state == DONE;
    assign correct_index_x = 32'(x);
    assign correct_index_y = 32'(y);

    cursor_counter #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .IW(12)) u_cursor (
        .clk(clk),
        .reset_n(reset_n),
        .inc(inc),
        .dec(dec),
        .clr(clr),
        .x(x),
        .y(y),
        .idx(letter_index)
    );

    always_comb begin
        next = state;
        inc = 1'b0;
        dec = 1'b0;
        clr = 1'b0;
        accept = 1'b0;
        hit_d = 1'b0;
        miss_d = 1'b0;
        case (state)
            PEEK: next = (prompt_char == ASCII_NUL || letter_index == END_IDX) ? DONE : IDLE;
            IDLE: begin
                accept = key_valid;
                next = key_valid ? CHECK : IDLE;
            end
            CHECK: begin
`ifdef TRACKER_BACKSPACE_EN
                if (key_q == ASCII_BS) begin
                    dec = 1'b1;
                    next = IDLE;
                end else
`endif
                if (key_q == prompt_char) begin
                    hit_d = 1'b1;
                    inc = 1'b1;
                    next = PEEK;
                end else begin
                    miss_d = 1'b1;
                    next = IDLE;
                end
            end
            DONE: begin
                clr = restart;
                next = restart ? PEEK : DONE;
            end
            default: next = PEEK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= PEEK;
            key_q <= '0;
            hit <= 1'b0;
            miss <= 1'b0;
            keystroke_cnt <= '0;
            error_cnt <= '0;
        end else begin
            state <= next;
            hit <= hit_d;
            miss <= miss_d;
            if (accept)
                key_q <= key_ascii[6:0];
            if (clr)
                keystroke_cnt <= '0;
            else if (accept && ~&keystroke_cnt)
                keystroke_cnt <= keystroke_cnt + 1'b1;
            if (clr)
                error_cnt <= '0;
            else if (miss_d && ~&error_cnt)
                error_cnt <= error_cnt + 1'b1;
        end
    end
endmodule
